accumulate_sched: RTL and testbench

ACCUMULATE_SCHED -- requirements
Module: accumulate_sched

---
 rtl/accumulate_sched_if.sv | 37 +++
 rtl/accumulate_sched.sv | 113 +++++++++++
 tb/tb_accumulate_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulate_sched_if.sv
// Request/grant and result bundle between requesters and accumulate_sched.
//   req[1:0]  : per-requester request (bit i = requester i)
//   x0, x1    : per-requester unsigned operand (XW bits)
//   n0, n1    : per-requester unsigned add count (NW bits)
//   gnt[1:0]  : one-hot grant pulse
//   owner     : requester index of the current / last completed job
//   busy      : scheduler not idle
//   sum       : accumulator value (SUMW bits)
//   done      : one-cycle completion pulse
interface accumulate_sched_if #(
    parameter int unsigned XW   = 5,
    parameter int unsigned NW   = 5,
    parameter int unsigned SUMW = 10
);
    logic [1:0]      req;
    logic [XW-1:0]   x0;
    logic [XW-1:0]   x1;
    logic [NW-1:0]   n0;
    logic [NW-1:0]   n1;
    logic [1:0]      gnt;
    logic            owner;
    logic            busy;
    logic [SUMW-1:0] sum;
    logic            done;

    // Requester side
    modport master (
        output req, x0, x1, n0, n1,
        input  gnt, owner, busy, sum, done
    );

    // Scheduler side
    modport slave (
        input  req, x0, x1, n0, n1,
        output gnt, owner, busy, sum, done
    );
endinterface

// File: rtl/accumulate_sched.sv
// Two-requester round-robin scheduler that runs a repeated-add job for the
// granted requester: sum = x * n, computed one add per clock.
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high reset
//   bus   : accumulate_sched_if.slave (req/x0/x1/n0/n1 in;
//           gnt/owner/busy/sum/done out)
module accumulate_sched #(
    parameter int unsigned XW   = 5,
    parameter int unsigned NW   = 5,
    parameter int unsigned SUMW = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    accumulate_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      gnt_q,   gnt_d;
    logic            done_q,  done_d;
    logic [SUMW-1:0] sum_q,   sum_d;
    logic            owner_q, owner_d;
    logic [NW-1:0]   cnt_q,   cnt_d;
    logic [XW-1:0]   xr_q,    xr_d;
    logic            prio_q,  prio_d;   // requester that wins a tie
    logic            pick;
    logic [NW-1:0]   n_sel;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = 2'b00;
        done_d  = 1'b0;
        sum_d   = sum_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        xr_d    = xr_q;
        prio_d  = prio_q;

        pick  = (bus.req == 2'b11) ? prio_q : bus.req[1];
        n_sel = pick ? bus.n1 : bus.n0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    owner_d = pick;
                    xr_d    = pick ? bus.x1 : bus.x0;
                    cnt_d   = n_sel;
                    sum_d   = '0;
                    prio_d  = ~pick;
                    // Zero-count job goes straight to DONE; its done pulse
                    // is deferred one cycle so it never overlaps gnt.
                    state_d = (n_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                sum_d = sum_q + SUMW'(xr_q);
                cnt_d = cnt_q - NW'(1);
                if (cnt_q == NW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // done_q low here only for the zero-count grant cycle.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 1'b0;
            sum_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            xr_q    <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            xr_q    <= xr_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_accumulate_sched.sv
// Directed testbench for accumulate_sched: default instance plus a SUMW=8
// instance for the wrap-around case.
module tb_accumulate_sched;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    accumulate_sched_if #(.XW(5), .NW(5), .SUMW(10)) bus ();
    accumulate_sched_if #(.XW(5), .NW(5), .SUMW(8))  bus8 ();

    accumulate_sched #(.XW(5), .NW(5), .SUMW(10)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    accumulate_sched #(.XW(5), .NW(5), .SUMW(8)) dut8 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus8.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.req = 2'b00; bus.x0 = '0; bus.x1 = '0; bus.n0 = '0; bus.n1 = '0;
        bus8.req = 2'b00; bus8.x0 = '0; bus8.x1 = '0; bus8.n0 = '0; bus8.n1 = '0;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.owner, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.gnt, bus.done, bus.owner, bus.busy});
        end
        checks++;
        if (bus.sum !== 10'd0) begin
            errors++;
            $display("FAIL reset_sum got=%0d exp=0", bus.sum);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit seen;
        bus.x0 = 5'd3; bus.n0 = 5'd4; bus.req = 2'b01;
        tick();
        checks++;
        if ({bus.gnt, bus.owner, bus.busy, bus.done} !== 5'b01010) begin
            errors++;
            $display("FAIL single_grant got=%b exp=01010", {bus.gnt, bus.owner, bus.busy, bus.done});
        end
        checks++;
        if (bus.sum !== 10'd0) begin
            errors++;
            $display("FAIL single_grant_sum got=%0d exp=0", bus.sum);
        end
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b1 || bus.sum !== 10'd3) begin
            errors++;
            $display("FAIL single_run1 got gnt=%b busy=%b sum=%0d exp gnt=00 busy=1 sum=3",
                     bus.gnt, bus.busy, bus.sum);
        end
        wait_done(10, cyc, seen);
        checks++;
        if (!seen || cyc != 3) begin
            errors++;
            $display("FAIL single_done_latency got seen=%0d cyc=%0d exp seen=1 cyc=3", seen, cyc);
        end
        checks++;
        if (bus.sum !== 10'd12 || bus.owner !== 1'b0 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_result got sum=%0d owner=%0d gnt=%b exp sum=12 owner=0 gnt=00",
                     bus.sum, bus.owner, bus.gnt);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 10'd12 || bus.owner !== 1'b0) begin
            errors++;
            $display("FAIL single_hold got done=%b busy=%b sum=%0d owner=%0d exp 0 0 12 0",
                     bus.done, bus.busy, bus.sum, bus.owner);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt [4];
        logic [9:0]  exp_sum [4];
        int          exp_cyc [4];
        int          cyc;
        bit          seen;
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_sum = '{10'd4, 10'd15, 10'd4, 10'd15};
        exp_cyc = '{2, 3, 2, 3};
        do_reset();
        bus.x0 = 5'd2; bus.n0 = 5'd2; bus.x1 = 5'd5; bus.n1 = 5'd3; bus.req = 2'b11;
        tick();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (bus.gnt !== exp_gnt[j] || bus.owner !== exp_gnt[j][1]) begin
                errors++;
                $display("FAIL rr_grant%0d got gnt=%b owner=%0d exp gnt=%b", j, bus.gnt, bus.owner, exp_gnt[j]);
            end
            wait_done(10, cyc, seen);
            checks++;
            if (!seen || cyc != exp_cyc[j] || bus.sum !== exp_sum[j]) begin
                errors++;
                $display("FAIL rr_done%0d got seen=%0d cyc=%0d sum=%0d exp cyc=%0d sum=%0d",
                         j, seen, cyc, bus.sum, exp_cyc[j], exp_sum[j]);
            end
            if (j == 3) bus.req = 2'b00;
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
                errors++;
                $display("FAIL rr_idle%0d got busy=%b gnt=%b exp busy=0 gnt=00", j, bus.busy, bus.gnt);
            end
            tick();
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_release got busy=%b gnt=%b exp busy=0 gnt=00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_zero_count();
        bus.x1 = 5'd7; bus.n1 = 5'd0; bus.req = 2'b10;
        tick();
        checks++;
        if ({bus.gnt, bus.owner, bus.busy, bus.done} !== 5'b10110 || bus.sum !== 10'd0) begin
            errors++;
            $display("FAIL zero_grant got ctl=%b sum=%0d exp ctl=10110 sum=0",
                     {bus.gnt, bus.owner, bus.busy, bus.done}, bus.sum);
        end
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.gnt !== 2'b00 || bus.sum !== 10'd0 || bus.owner !== 1'b1) begin
            errors++;
            $display("FAIL zero_done got done=%b gnt=%b sum=%0d owner=%0d exp 1 00 0 1",
                     bus.done, bus.gnt, bus.sum, bus.owner);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_capture();
        int cyc;
        bit seen;
        bus.x0 = 5'd3; bus.n0 = 5'd3; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        bus.x0 = 5'd9; bus.n0 = 5'd7;
        wait_done(10, cyc, seen);
        checks++;
        if (!seen || cyc != 2 || bus.sum !== 10'd9) begin
            errors++;
            $display("FAIL capture got seen=%0d cyc=%0d sum=%0d exp seen=1 cyc=2 sum=9", seen, cyc, bus.sum);
        end
        tick();
    endtask

    task automatic test_overflow();
        int cyc;
        bit seen;
        bus.x0 = 5'd31;  bus.n0 = 5'd31;  bus.req = 2'b01;
        bus8.x0 = 5'd31; bus8.n0 = 5'd31; bus8.req = 2'b01;
        tick();
        bus.req = 2'b00; bus8.req = 2'b00;
        checks++;
        if (bus.gnt !== 2'b01 || bus8.gnt !== 2'b01) begin
            errors++;
            $display("FAIL ovf_grant got gnt=%b gnt8=%b exp 01 01", bus.gnt, bus8.gnt);
        end
        wait_done(40, cyc, seen);
        checks++;
        if (!seen || cyc != 31 || bus.sum !== 10'd961) begin
            errors++;
            $display("FAIL max_sum got seen=%0d cyc=%0d sum=%0d exp seen=1 cyc=31 sum=961", seen, cyc, bus.sum);
        end
        checks++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'd193) begin
            errors++;
            $display("FAIL wrap_sum8 got done=%b sum=%0d exp done=1 sum=193", bus8.done, bus8.sum);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit saw;
        bus.x0 = 5'd4; bus.n0 = 5'd10; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        checks++;
        if (bus.sum !== 10'd8 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got sum=%0d busy=%b exp sum=8 busy=1", bus.sum, bus.busy);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.sum !== 10'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL midrst_async got sum=%0d busy=%b done=%b gnt=%b exp 0 0 0 00",
                     bus.sum, bus.busy, bus.done, bus.gnt);
        end
        tick();
        Reset = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL midrst_quiet got activity=1 exp activity=0");
        end
        bus.x0 = 5'd2; bus.n0 = 5'd1; bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        checks++;
        if (bus.gnt !== 2'b01 || bus.sum !== 10'd0) begin
            errors++;
            $display("FAIL midrst_regrant got gnt=%b sum=%0d exp gnt=01 sum=0", bus.gnt, bus.sum);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.sum !== 10'd2) begin
            errors++;
            $display("FAIL midrst_fresh got done=%b sum=%0d exp done=1 sum=2", bus.done, bus.sum);
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_capture();
        test_overflow();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
